// File: rtl/reg_write_buffer.sv
// Purpose: in-order writeback FIFO in front of the register file write port, with read-address snoop forwarding.
// Latency: an accept at edge N drives regwrite during N..N+1 (empty buffer, no stall); bypass is combinational from the last edge.
// Backpressure: in_ready = !full, so a pop does not reopen the input until the next cycle; drain_stall holds the head in place.
// Build option: define REG_WRITE_BUFFER_BYPASS_EN to build the bypass comparators; otherwise byp_* outputs are tied to 0.
module reg_write_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     drain_stall,
    output logic                     regwrite,
    output logic [4:0]               write_reg,
    output logic [XLEN-1:0]          write_data,
    input  logic [4:0]               read_reg1,
    input  logic [4:0]               read_reg2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [XLEN-1:0]          byp_data1,
    output logic [XLEN-1:0]          byp_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      ent_reg  [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   cnt;
    logic            full;
    logic            push;
    logic            pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign in_ready = !full;

    // x0 writes complete the handshake but are dropped rather than queued
    assign push       = in_valid && in_ready && (in_reg != 5'd0);
    assign regwrite   = !empty && !drain_stall;
    assign pop        = regwrite;
    assign write_reg  = empty ? 5'd0 : ent_reg[head];
    assign write_data = empty ? '0   : ent_data[head];

    // Entry storage: contents are qualified by count, so no reset needed
    always_ff @(posedge clock) begin
        if (push) begin
            ent_reg[tail]  <= in_reg;
            ent_data[tail] <= in_data;
        end
    end

    // Pointer and occupancy update; reset discards every pending entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef REG_WRITE_BUFFER_BYPASS_EN
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the last match (nearest the tail) wins
    always_comb begin
        idx       = '0;
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < cnt) begin
                if ((read_reg1 != 5'd0) && (ent_reg[idx] == read_reg1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = ent_data[idx];
                end
                if ((read_reg2 != 5'd0) && (ent_reg[idx] == read_reg2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = ent_data[idx];
                end
            end
        end
    end
`else
    // Without forwarding, readers must wait for empty before reading
    logic unused_read_addrs;
    assign unused_read_addrs = ^{read_reg1, read_reg2};
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_write_buffer.sv
// Purpose: directed bench for reg_write_buffer: reset, single write, x0 drop, full/stall, bypass, reset mid-queue.
// Latency: inputs change 1ns after a rising edge; outputs are sampled 1ns later, well away from the edge.
// Backpressure: drain_stall is driven directly to fill the buffer and to hold entries for bypass.
module tb_reg_write_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_reg = '0;
    logic [63:0] in_data = '0;
    logic        drain_stall = 1'b0;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [63:0] byp_data1;
    logic [63:0] byp_data2;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;
    int pulses;

    reg_write_buffer #(.DEPTH(4), .XLEN(64)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .drain_stall(drain_stall),
        .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
        .count(count), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with a request pending
        in_valid  = 1'b1;
        in_reg    = 5'd7;
        in_data   = 64'h77;
        read_reg1 = 5'd7;
        step();
        step();
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_regwrite", regwrite, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_write_reg", write_reg, 5'd0);
        check("rst_write_data", write_data, 64'h0);
        check("rst_byp_hit1", byp_hit1, 1'b0);
        check("rst_byp_data1", byp_data1, 64'h0);
        in_valid  = 1'b0;
        read_reg1 = 5'd0;
        reset     = 1'b1;
        step();

        // Single write commits one cycle after accept
        in_valid = 1'b1;
        in_reg   = 5'd2;
        in_data  = 64'h1000;
        step();
        in_valid = 1'b0;
        #1;
        check("single_regwrite", regwrite, 1'b1);
        check("single_write_reg", write_reg, 5'd2);
        check("single_write_data", write_data, 64'h1000);
        check("single_count", count, 3'd1);
        step();
        #1;
        check("single_empty", empty, 1'b1);
        check("single_regwrite_after", regwrite, 1'b0);

        // x0 request is handshaken but dropped
        in_valid = 1'b1;
        in_reg   = 5'd0;
        in_data  = 64'hFFFF_FFFF;
        #1;
        check("x0_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        #1;
        check("x0_count", count, 3'd0);
        check("x0_regwrite", regwrite, 1'b0);
        check("x0_empty", empty, 1'b1);

        // Fill under stall with x1..x4
        drain_stall = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            in_valid = 1'b1;
            in_reg   = 5'(r);
            in_data  = 64'(r * 16);
            step();
        end
        in_valid = 1'b0;
        #1;
        check("full_count", count, 3'd4);
        check("full_in_ready", in_ready, 1'b0);
        check("full_regwrite_stalled", regwrite, 1'b0);
        // Request while full must not be taken
        in_valid = 1'b1;
        in_reg   = 5'd9;
        in_data  = 64'h99;
        step();
        in_valid = 1'b0;
        #1;
        check("full_reject_count", count, 3'd4);

        // Release stall: four in-order commits; pop while full keeps in_ready low
        drain_stall = 1'b0;
        #1;
        check("full_pop_in_ready", in_ready, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            check("drain_regwrite", regwrite, 1'b1);
            check("drain_write_reg", write_reg, 5'(k));
            check("drain_write_data", write_data, 64'(k * 16));
            step();
            if (k == 1) begin
                check("after_pop_in_ready", in_ready, 1'b1);
            end
        end
        #1;
        check("drain_empty", empty, 1'b1);

        // Simultaneous accept and pop at count 3
        drain_stall = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            in_valid = 1'b1;
            in_reg   = 5'(r);
            in_data  = 64'(r * 17);
            step();
        end
        drain_stall = 1'b0;
        in_reg      = 5'd6;
        in_data     = 64'h66;
        step();
        in_valid = 1'b0;
        #1;
        check("simul_count", count, 3'd3);
        check("simul_head_reg", write_reg, 5'd2);
        check("simul_head_data", write_data, 64'h22);
        step();
        check("simul_next_reg", write_reg, 5'd3);
        step();
        check("simul_last_reg", write_reg, 5'd6);
        check("simul_last_data", write_data, 64'h66);
        step();
        #1;
        check("simul_empty", empty, 1'b1);

        // Bypass: two pending writes to x5, youngest must win
        drain_stall = 1'b1;
        in_valid    = 1'b1;
        in_reg      = 5'd5;
        in_data     = 64'hA;
        step();
        in_data     = 64'hB;
        step();
        in_valid  = 1'b0;
        read_reg1 = 5'd5;
        read_reg2 = 5'd3;
        #1;
`ifdef REG_WRITE_BUFFER_BYPASS_EN
        check("byp_hit1_x5", byp_hit1, 1'b1);
        check("byp_data1_x5", byp_data1, 64'hB);
`else
        check("byp_off_hit1", byp_hit1, 1'b0);
        check("byp_off_data1", byp_data1, 64'h0);
`endif
        check("byp_hit2_x3", byp_hit2, 1'b0);
        check("byp_data2_x3", byp_data2, 64'h0);
        // Same-cycle incoming data is not forwarded
        in_valid = 1'b1;
        in_reg   = 5'd3;
        in_data  = 64'hC;
        #1;
        check("byp_no_incoming", byp_hit2, 1'b0);
        in_valid  = 1'b0;
        read_reg1 = 5'd0;
        #1;
        check("byp_x0_nohit", byp_hit1, 1'b0);
        // Head being written still hits
        drain_stall = 1'b0;
        read_reg1   = 5'd5;
        #1;
`ifdef REG_WRITE_BUFFER_BYPASS_EN
        check("byp_head_hit", byp_hit1, 1'b1);
`endif
        check("byp_commit_a_reg", write_reg, 5'd5);
        check("byp_commit_a_data", write_data, 64'hA);
        step();
        check("byp_commit_b_data", write_data, 64'hB);
        check("byp_commit_b_we", regwrite, 1'b1);
        step();
        #1;
        check("byp_drained", empty, 1'b1);
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;

        // Reset mid-queue discards three pending entries
        drain_stall = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            in_valid = 1'b1;
            in_reg   = 5'(r);
            in_data  = 64'(r);
            step();
        end
        in_valid = 1'b0;
        #1;
        check("midrst_pre_count", count, 3'd3);
        reset = 1'b0;
        #1;
        check("midrst_count", count, 3'd0);
        check("midrst_empty", empty, 1'b1);
        drain_stall = 1'b0;
        #1;
        check("midrst_regwrite", regwrite, 1'b0);
        reset  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (regwrite) pulses++;
        end
        check("midrst_no_pulses", 64'(pulses), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_buffer.md
# reg_write_buffer

Write-side companion to the register file: collects register writeback requests from the execute and load units through a valid/ready handshake, queues them in a small in-order FIFO, and drains one entry per cycle onto the register file's write port (`regwrite`/`write_reg`/`write_data`). It also snoops the register file's two read addresses and forwards the youngest pending value for each. Pending writes are therefore visible to readers before they commit.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `XLEN`, 64: data width; matches register file width.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `in_valid`  in  1  writeback request present.
- `in_ready`  out  1  buffer can accept; equals `!full`.
- `in_reg`  in  5  destination register index.
- `in_data`  in  XLEN  destination value.
- `drain_stall`  in  1  1 = register file must not be written this cycle.
- `regwrite`  out  1  write enable to register file.
- `write_reg`  out  5  register file write address (head entry).
- `write_data`  out  XLEN  register file write data (head entry).
- `read_reg1`, `read_reg2`  in  5 each  snooped register file read addresses.
- `byp_hit1`, `byp_hit2`  out  1 each  pending write exists for the address.
- `byp_data1`, `byp_data2`  out  XLEN each  youngest pending value for the address.
- `count`  out  clog2(DEPTH)+1  occupied entries.
- `empty`  out  1  `count == 0`.

## Operation
- Accept occurs when `in_valid && in_ready` at a rising edge. The entry is written at the tail; the tail pointer increments modulo DEPTH.
- `in_reg == 0`: the handshake completes normally, but nothing is enqueued and `count` is unchanged. x0 is never written.
- Drain: `regwrite = !empty && !drain_stall`. `write_reg`/`write_data` always show the head entry, or 0 when the buffer is empty. At an edge where `regwrite` is 1, the head pops and the head pointer increments modulo DEPTH.
- Simultaneous accept and pop: `count` is unchanged and both pointers advance.
- When full, `in_ready` is 0. A pop in the same cycle does not raise `in_ready` combinationally; it rises the cycle after.
- Ordering is strict FIFO. Multiple entries for the same register commit oldest-first, so the final register value is the youngest.
- Bypass:
  - Each valid entry is compared against `read_reg1` and `read_reg2`.
  - When several entries match, the youngest (nearest the tail) wins.
  - An address of 0 never hits.
  - The head entry being written this cycle still counts as a hit.
  - On a miss, `byp_data` is 0.
- Only state: entry array, head pointer, tail pointer, and a count register. There is no separate state machine. Modes are EMPTY (count 0), PARTIAL, and FULL (count == DEPTH).

## Timing
- Reset values (asynchronous, effective immediately while `reset` is 0):
  - head = tail = count = 0; `empty` = 1; `in_ready` = 1.
  - `regwrite` = 0; `write_reg` = 0; `write_data` = 0.
  - All `byp_hit*` = 0 and all `byp_data*` = 0.
  - Entry contents are don't-care, but are masked by valid.
- Reset mid-operation discards all pending entries. They are never written to the register file.
- Commit latency: an entry accepted at edge N into an empty buffer with `drain_stall` low has `regwrite` = 1 during cycle N→N+1 and is written at edge N+1.
- Bypass latency is 0 cycles: `byp_*` reflects the entries accepted up to the last edge, combinationally from `read_reg*`. The same-cycle incoming `in_data` is not forwarded.
- Throughput: 1 accept and 1 commit per cycle sustained.
- With `drain_stall` held, the buffer fills after DEPTH accepts and `in_ready` falls the following cycle.

## Configuration
- Macro `REG_WRITE_BUFFER_BYPASS_EN`.
- Defined: bypass comparators and youngest-match priority logic are built as described above.
- Undefined: `byp_hit1`/`byp_hit2` are tied to 0 and `byp_data1`/`byp_data2` to 0; no comparator logic is generated. Consumers must instead stall until `empty` = 1. Handshake and drain behaviour are identical in both builds.

## Test plan
- Reset checks:
  - Hold `reset` = 0 with `in_valid` = 1 → `in_ready` = 1, `regwrite` = 0, `count` = 0, `empty` = 1.
  - Assert `reset` = 0 mid-queue with 3 entries pending → `count` returns to 0 immediately and no further `regwrite` pulses occur.
- Single write: accept (`in_reg` = 2, `in_data` = 64'h1000) → next cycle `regwrite` = 1, `write_reg` = 2, `write_data` = 64'h1000; then `empty` = 1.
- x0 drop: accept (`in_reg` = 0, `in_data` = 64'hFFFF_FFFF) → `in_ready` stays 1, `count` stays 0, and `regwrite` never asserts.
- Full and stall:
  - With `drain_stall` = 1, accept writes to x1..x4 → `count` = 4 and `in_ready` = 0.
  - Release the stall → four consecutive `regwrite` cycles with `write_reg` = 1, 2, 3, 4 in order.
  - A simultaneous accept at count = 3 leaves `count` = 3.
- Bypass priority (`REG_WRITE_BUFFER_BYPASS_EN` defined):
  - Stall the drain and enqueue x5←64'hA, then x5←64'hB.
  - `read_reg1` = 5 → `byp_hit1` = 1, `byp_data1` = 64'hB.
  - `read_reg2` = 3 → `byp_hit2` = 0, `byp_data2` = 0.
  - `read_reg1` = 0 → no hit.
- Bypass compiled out (macro undefined): the same stimulus → `byp_hit1` = `byp_hit2` = 0, and commits still occur in order A then B.
